ssd_scan_driver: RTL and testbench

//  Time-multiplexes the two 7-segment digit patterns produced by bin_to_ssd (seg1 = tens, seg0 = ones)

---
 rtl/ssd_pkg.sv | 20 ++
 rtl/ssd_slot_timer.sv | 37 +++
 rtl/ssd_scan_driver.sv | 141 ++++++++++++++
 tb/tb_ssd_scan_driver.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg
//   Shared constants and FSM state encoding for the 7-segment scan driver.
//   Segment patterns are active-low, bit0 = a .. bit6 = g.
package ssd_pkg;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_ZERO = 7'h40;

    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_TENS = 4'b1101;

    typedef enum logic [1:0] {
        SHOW0 = 2'd0,
        GAP0  = 2'd1,
        SHOW1 = 2'd2,
        GAP1  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/ssd_slot_timer.sv
// ssd_slot_timer
//   Down-counter that times one FSM state visit. A load writes the number of
//   remaining cycles minus one; the count then steps down while enabled and
//   parks at zero, where o_tc is raised.
// Ports
//   i_clk       system clock, rising edge
//   i_rst       asynchronous active-high reset (count -> 0)
//   i_en        count enable
//   i_load      load i_load_val (takes priority over counting)
//   i_load_val  cycles-minus-one for the state being entered
//   o_tc        terminal count: current cycle is the last of the visit
module ssd_slot_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
//   Time-multiplexes the tens/ones 7-segment patterns onto a shared cathode
//   bus and the common anodes. Both patterns are captured once per frame so a
//   digit never tears mid-scan, and a dark gap follows each digit slot.
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   en          1 = scan, 0 = freeze position and blank the display
//   blank_tens  suppress tens digit when it shows '0' (sampled live)
//   seg1_in     tens pattern, active-low
//   seg0_in     ones pattern, active-low
//   seg_out     cathode bus, active-low (registered)
//   an          anodes, active-low; an[0] = ones, an[1] = tens (registered)
//   dp          decimal point, always off
//   frame_tick  one-cycle pulse on the cycle new patterns are captured
//
// state | meaning
// SHOW0 | ones digit lit (SLOT-BLANK_CYCLES cycles)
// GAP0  | dark gap after ones (BLANK_CYCLES cycles)
// SHOW1 | tens digit lit (SLOT-BLANK_CYCLES cycles)
// GAP1  | dark gap after tens; leaving it captures a new frame
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 500,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       blank_tens,
    input  logic [6:0] seg1_in,
    input  logic [6:0] seg0_in,
    output logic [6:0] seg_out,
    output logic [3:0] an,
    output logic       dp,
    output logic       frame_tick
);

    localparam int SLOT        = CLK_HZ / (2 * REFRESH_HZ);
    localparam int SHOW_CYCLES = SLOT - BLANK_CYCLES;
    localparam int CW          = $clog2(SLOT);

    localparam logic [CW-1:0] LD_SHOW = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] LD_GAP  = CW'(BLANK_CYCLES - 1);

    scan_state_t r_state, w_state_nxt;

    logic [6:0]    r_ones, r_tens;
    logic [6:0]    w_ones_nxt, w_tens_nxt;
    logic [6:0]    r_seg, w_seg_nxt;
    logic [3:0]    r_an, w_an_nxt;
    logic          r_tick, w_tick_nxt;
    logic          w_tc, w_adv, w_capture;
    logic [CW-1:0] w_load_val;

    // Reset leaves the timer at zero in GAP1, i.e. on the last GAP1 cycle,
    // so the first enabled edge after reset is the capture edge.
    ssd_slot_timer #(.W(CW)) u_timer (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_en       (en),
        .i_load     (w_adv),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    assign w_adv      = en & w_tc;
    assign w_capture  = w_adv & (r_state == GAP1);
    assign w_load_val = ((r_state == SHOW0) || (r_state == SHOW1)) ? LD_GAP : LD_SHOW;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= GAP1;
            r_ones  <= SEG_OFF;
            r_tens  <= SEG_OFF;
            r_seg   <= SEG_OFF;
            r_an    <= AN_OFF;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ones  <= w_ones_nxt;
            r_tens  <= w_tens_nxt;
            r_seg   <= w_seg_nxt;
            r_an    <= w_an_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // Outputs are derived from the next state and next latch contents so they
    // change on the same edge as the state, including the capture edge.
    always_comb begin
        w_state_nxt = r_state;
        w_ones_nxt  = r_ones;
        w_tens_nxt  = r_tens;
        w_seg_nxt   = SEG_OFF;
        w_an_nxt    = AN_OFF;
        w_tick_nxt  = w_capture;

        if (w_adv) begin
            unique case (r_state)
                SHOW0:   w_state_nxt = GAP0;
                GAP0:    w_state_nxt = SHOW1;
                SHOW1:   w_state_nxt = GAP1;
                GAP1:    w_state_nxt = SHOW0;
                default: w_state_nxt = GAP1;
            endcase
        end

        if (w_capture) begin
            w_ones_nxt = seg0_in;
            w_tens_nxt = seg1_in;
        end

        if (en) begin
            unique case (w_state_nxt)
                SHOW0: begin
                    w_an_nxt  = AN_ONES;
                    w_seg_nxt = w_ones_nxt;
                end
                SHOW1: begin
                    if (!(blank_tens && (w_tens_nxt == SEG_ZERO))) begin
                        w_an_nxt  = AN_TENS;
                        w_seg_nxt = w_tens_nxt;
                    end
                end
                default: begin
                    w_an_nxt  = AN_OFF;
                    w_seg_nxt = SEG_OFF;
                end
            endcase
        end
    end

    assign seg_out    = r_seg;
    assign an         = r_an;
    assign dp         = 1'b1;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_ssd_scan_driver.sv
module tb_ssd_scan_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       blank_tens;
    logic [6:0] seg1_in;
    logic [6:0] seg0_in;
    logic [6:0] seg_out;
    logic [3:0] an;
    logic       dp;
    logic       frame_tick;

    int checks   = 0;
    int failures = 0;

    ssd_scan_driver #(
        .CLK_HZ       (40),
        .REFRESH_HZ   (2),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .blank_tens (blank_tens),
        .seg1_in    (seg1_in),
        .seg0_in    (seg0_in),
        .seg_out    (seg_out),
        .an         (an),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       bt;
        logic [6:0] s1;
        logic [6:0] s0;
        logic [3:0] an;
        logic [6:0] seg;
        logic       chk_seg;
        logic       tick;
    } vec_t;

    vec_t vecs[80];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic edge_chk(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                            input logic e_tick);
        @(posedge clk);
        #1;
        check({name, " an"}, an, e_an);
        check({name, " seg"}, seg_out, e_seg);
        check({name, " tick"}, frame_tick, e_tick);
    endtask

    // Digit '2' on ones, '1' on tens: one full frame plus the next frame_tick.
    task automatic frame_12(input string name);
        for (int p = 0; p <= 20; p++) begin
            if (p == 0 || p == 20)      edge_chk($sformatf("%s p%0d", name, p), 4'b1110, 7'h24, 1'b1);
            else if (p < 8)             edge_chk($sformatf("%s p%0d", name, p), 4'b1110, 7'h24, 1'b0);
            else if (p < 10 || p >= 18) edge_chk($sformatf("%s p%0d", name, p), 4'b1111, 7'h7F, 1'b0);
            else                        edge_chk($sformatf("%s p%0d", name, p), 4'b1101, 7'h79, 1'b0);
        end
    endtask

    initial begin
        int         since_tick;
        int         ticks;
        logic [6:0] ones, tens;

        // Stimulus/expectation table for scan, mid-frame input change and
        // leading-zero blanking. Vector k is applied before edge k, edge 0
        // being the first edge after reset release.
        for (int k = 0; k < 80; k++) begin
            int f, p;
            f = k / 20;
            p = k % 20;
            vecs[k].en      = 1'b1;
            vecs[k].s0      = (k < 10) ? 7'h24 : 7'h30;
            vecs[k].s1      = (k < 25) ? 7'h79 : 7'h40;
            vecs[k].bt      = (k >= 25 && k < 60);
            vecs[k].tick    = (p == 0);
            vecs[k].chk_seg = 1'b1;
            ones = (f == 0) ? 7'h24 : 7'h30;
            tens = (f < 2)  ? 7'h79 : 7'h40;
            if (p < 8) begin
                vecs[k].an  = 4'b1110;
                vecs[k].seg = ones;
            end else if (p < 10 || p >= 18) begin
                vecs[k].an  = 4'b1111;
                vecs[k].seg = 7'h7F;
            end else if (vecs[k].bt && tens == 7'h40) begin
                vecs[k].an      = 4'b1111;
                vecs[k].seg     = 7'h7F;
                vecs[k].chk_seg = 1'b0;
            end else begin
                vecs[k].an  = 4'b1101;
                vecs[k].seg = tens;
            end
        end

        // Reset state, asserted with no clock edge yet
        reset      = 1'b1;
        en         = 1'b1;
        blank_tens = 1'b0;
        seg1_in    = 7'h79;
        seg0_in    = 7'h24;
        #1;
        check("reset seg", seg_out, 7'h7F);
        check("reset an", an, 4'hF);
        check("reset dp", dp, 1'b1);
        check("reset tick", frame_tick, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset held an", an, 4'hF);
        reset = 1'b0;

        for (int k = 0; k < 80; k++) begin
            en         = vecs[k].en;
            blank_tens = vecs[k].bt;
            seg1_in    = vecs[k].s1;
            seg0_in    = vecs[k].s0;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d an", k), an, vecs[k].an);
            if (vecs[k].chk_seg) check($sformatf("vec%0d seg", k), seg_out, vecs[k].seg);
            check($sformatf("vec%0d tick", k), frame_tick, vecs[k].tick);
        end

        // Freeze mid-SHOW0: 4 ones cycles, 15 frozen, then the remaining 4
        seg0_in    = 7'h30;
        seg1_in    = 7'h40;
        blank_tens = 1'b0;
        edge_chk("hold pre0", 4'b1110, 7'h30, 1'b1);
        for (int i = 1; i < 4; i++) edge_chk($sformatf("hold pre%0d", i), 4'b1110, 7'h30, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 15; i++) edge_chk($sformatf("hold off%0d", i), 4'b1111, 7'h7F, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) edge_chk($sformatf("hold post%0d", i), 4'b1110, 7'h30, 1'b0);
        for (int i = 0; i < 2; i++) edge_chk($sformatf("hold gap%0d", i), 4'b1111, 7'h7F, 1'b0);
        for (int i = 0; i < 3; i++) edge_chk($sformatf("hold show1_%0d", i), 4'b1101, 7'h40, 1'b0);

        // Async reset mid-SHOW1, then a clean restart
        #2;
        reset = 1'b1;
        #1;
        check("midreset an", an, 4'hF);
        check("midreset seg", seg_out, 7'h7F);
        check("midreset tick", frame_tick, 1'b0);
        seg1_in = 7'h79;
        seg0_in = 7'h24;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midreset held an", an, 4'hF);
        reset = 1'b0;
        frame_12("restart");

        // 100 random frames: anode invariants, dp, frame period and capture
        since_tick = 0;
        ticks      = 0;
        for (int c = 0; c < 2000; c++) begin
            logic [6:0] s0;
            s0         = 7'($urandom_range(0, 127));
            seg0_in    = s0;
            seg1_in    = ($urandom_range(0, 3) == 0) ? 7'h40 : 7'($urandom_range(0, 127));
            blank_tens = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            since_tick++;
            check("rand an onehot", {31'd0, (~an[0] & ~an[1])}, 32'd0);
            check("rand an hi", an[3:2], 2'b11);
            check("rand dp", dp, 1'b1);
            if (frame_tick) begin
                ticks++;
                check("rand period", since_tick, 20);
                check("rand capture seg", seg_out, s0);
                check("rand capture an", an, 4'b1110);
                since_tick = 0;
            end
        end
        check("rand tick count", ticks, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
